// File: rtl/hit_pattern_gen.sv
// Programmable hit burst generator for TDC self-test: fixed, jittered-gap or round-robin pulses.
// Outputs registered; an accepted start shows on hit/busy one cycle later; abort clears next cycle.
module hit_pattern_gen #(
   parameter int N_CH    = 4,
   parameter int CNT_W   = 16,
   parameter int BURST_W = 16,
   parameter int LFSR_W  = 16,
   parameter int JIT_W   = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         mode,
   input  logic [CNT_W-1:0]   high_cycles,
   input  logic [CNT_W-1:0]   low_cycles,
   input  logic [BURST_W-1:0] burst_len,
   input  logic [N_CH-1:0]    ch_enable,
   input  logic [LFSR_W-1:0]  seed,
   output logic [N_CH-1:0]    hit,
   output logic               busy,
   output logic               done,
   output logic [BURST_W-1:0] pulse_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HIGH = 2'd1;
   localparam logic [1:0] S_LOW  = 2'd2;
   localparam int RR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [RR_W-1:0]   RR_LAST   = RR_W'(N_CH - 1);
   localparam logic [LFSR_W-1:0] LFSR_INIT = LFSR_W'(16'hACE1);
   localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400);
   localparam logic [CNT_W:0]    CNT_ONE   = {{CNT_W{1'b0}}, 1'b1};

   logic [1:0]         state_q, state_d;
   logic [CNT_W:0]     cnt_q, cnt_d;
   logic [BURST_W-1:0] pcnt_q, pcnt_d;
   logic [N_CH-1:0]    hit_q, hit_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic [LFSR_W-1:0]  lfsr_q, lfsr_d, lfsr_adv;
   logic [RR_W-1:0]    rr_q, rr_d, rr_nxt, rr_first;
   logic [1:0]         mode_q, mode_d;
   logic [CNT_W-1:0]   high_q, high_d, low_q, low_d, low_base;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic [N_CH-1:0]    en_q, en_d;
   logic [CNT_W:0]     jit, low_len;
   logic               start_ok;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      logic [LFSR_W-1:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ LFSR_TAPS;
      return n;
   endfunction

   // Next enabled channel strictly after cur, wrapping; cur itself is found last.
   function automatic logic [RR_W-1:0] next_en(input logic [RR_W-1:0] cur, input logic [N_CH-1:0] mask);
      logic [RR_W-1:0] idx, res;
      logic            found;
      idx   = cur;
      res   = cur;
      found = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         idx = (idx == RR_LAST) ? '0 : idx + RR_W'(1);
         if (!found && mask[idx]) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   function automatic logic [N_CH-1:0] pattern(input logic [1:0] m, input logic [N_CH-1:0] en,
                                               input logic [RR_W-1:0] idx);
      logic [N_CH-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return (m == 2'b10) ? oh : en;
   endfunction

   always_comb begin
      lfsr_adv = lfsr_step(lfsr_q);
      jit      = (mode_q == 2'b01) ? {{(CNT_W + 1 - JIT_W){1'b0}}, lfsr_adv[JIT_W-1:0]} : '0;
      low_base = (low_q == '0) ? {{(CNT_W - 1){1'b0}}, 1'b1} : low_q;
      low_len  = {1'b0, low_base} + jit;
      rr_nxt   = next_en(rr_q, en_q);
      rr_first = next_en(RR_LAST, ch_enable);
      start_ok = start && (burst_len != '0) && (high_cycles != '0) && (ch_enable != '0);

      state_d = state_q;
      cnt_d   = cnt_q;
      pcnt_d  = pcnt_q;
      hit_d   = hit_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      lfsr_d  = lfsr_q;
      rr_d    = rr_q;
      mode_d  = mode_q;
      high_d  = high_q;
      low_d   = low_q;
      burst_d = burst_q;
      en_d    = en_q;

      if (abort) begin
         state_d = S_IDLE;
         hit_d   = '0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  mode_d  = mode;
                  high_d  = high_cycles;
                  low_d   = low_cycles;
                  burst_d = burst_len;
                  en_d    = ch_enable;
                  lfsr_d  = (seed == '0) ? LFSR_INIT : seed;
                  rr_d    = rr_first;
                  pcnt_d  = '0;
                  hit_d   = pattern(mode, ch_enable, rr_first);
                  busy_d  = 1'b1;
                  cnt_d   = {1'b0, high_cycles} - CNT_ONE;
                  state_d = S_HIGH;
               end
            end
            S_HIGH: begin
               if (cnt_q == '0) begin
                  state_d = S_LOW;
                  hit_d   = '0;
                  pcnt_d  = pcnt_q + BURST_W'(1);
                  // Gap jitter comes from the state the LFSR steps into on LOW entry.
                  lfsr_d  = lfsr_adv;
                  cnt_d   = low_len - CNT_ONE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            S_LOW: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_ONE;
               end else if (pcnt_q == burst_q) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_HIGH;
                  rr_d    = rr_nxt;
                  hit_d   = pattern(mode_q, en_q, rr_nxt);
                  cnt_d   = {1'b0, high_q} - CNT_ONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               hit_d   = '0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pcnt_q  <= '0;
         hit_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lfsr_q  <= LFSR_INIT;
         rr_q    <= '0;
         mode_q  <= '0;
         high_q  <= '0;
         low_q   <= '0;
         burst_q <= '0;
         en_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pcnt_q  <= pcnt_d;
         hit_q   <= hit_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         lfsr_q  <= lfsr_d;
         rr_q    <= rr_d;
         mode_q  <= mode_d;
         high_q  <= high_d;
         low_q   <= low_d;
         burst_q <= burst_d;
         en_q    <= en_d;
      end
   end

   assign hit         = hit_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pulse_count = pcnt_q;

endmodule
